i2c_master_byte: RTL and testbench

//  Byte-level I2C controller: the initiating end of the two-wire bus that the
//  i2c_slave (address 8'hA0) responds on. It accepts one command per handshake:

---
 rtl/i2c_master_byte_if.sv | 29 ++
 rtl/i2c_master_byte.sv | 145 ++++++++++++++
 tb/tb_i2c_master_byte.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_byte_if.sv
// Command handshake between a host and the byte-level I2C master.
// The host side uses modport master, the controller uses modport slave.
interface i2c_master_byte_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_read;
  logic       cmd_nack;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       ack_rx;
  logic       done;
  logic       busy;

  modport master (
    output cmd_valid, cmd_start, cmd_stop,
    output cmd_read, cmd_nack, tx_data,
    input  cmd_ready, rx_data, ack_rx,
    input  done, busy
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_stop,
    input  cmd_read, cmd_nack, tx_data,
    output cmd_ready, rx_data, ack_rx,
    output done, busy
  );
endinterface

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: optional START, one byte, ACK slot, optional STOP.
// Define I2C_CLK_STRETCH_EN to freeze the q2 quarter while scl_in is low.
module i2c_master_byte #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_oen,
  output logic sda_oen,
  i2c_master_byte_if.slave cmd
);
  localparam logic [15:0] QMAX = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_ACK, S_STOP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] qcnt;
  logic [1:0]  phase;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  rx_q;
  logic        samp;
  logic        r_stop;
  logic        r_read;
  logic        r_nack;
  logic        busy_q;
  logic        done_q;
  logic        ack_q;
  logic        accept;
  logic        in_bit;
  logic        freeze;
  logic        tick;
  logic        qwrap;

  assign accept = (state == S_IDLE) && cmd.cmd_valid;
  assign in_bit = (state == S_DATA) || (state == S_ACK);

`ifdef I2C_CLK_STRETCH_EN
  assign freeze = in_bit && (phase == 2'd2) && !scl_in;
`else
  assign freeze = 1'b0 & scl_in;
`endif

  assign tick  = (qcnt == QMAX) && !freeze;
  assign qwrap = tick && (phase == 2'd3);

  assign cmd.cmd_ready = (state == S_IDLE);
  assign cmd.rx_data   = rx_q;
  assign cmd.ack_rx    = ack_q;
  assign cmd.done      = done_q;
  assign cmd.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    scl_oen = 1'b1;
    sda_oen = 1'b1;
    unique case (state)
      S_IDLE: begin
        // a bus left open without STOP keeps SCL low
        scl_oen = !busy_q;
        if (accept) begin
          if (cmd.cmd_start || !busy_q) state_n = S_START;
          else                          state_n = S_DATA;
        end
      end
      S_START: begin
        sda_oen = (phase == 2'd0);
        scl_oen = !phase[1];
        if (qwrap) state_n = S_DATA;
      end
      S_DATA: begin
        scl_oen = phase[1];
        sda_oen = r_read | shreg[7];
        if (qwrap && bit_cnt == 3'd7) state_n = S_ACK;
      end
      S_ACK: begin
        scl_oen = phase[1];
        sda_oen = !r_read | r_nack;
        if (qwrap) state_n = r_stop ? S_STOP : S_IDLE;
      end
      S_STOP: begin
        scl_oen = (phase != 2'd0);
        sda_oen = phase[1];
        if (qwrap) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt    <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rx_q    <= '0;
      samp    <= 1'b1;
      r_stop  <= 1'b0;
      r_read  <= 1'b0;
      r_nack  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        qcnt    <= '0;
        phase   <= '0;
        bit_cnt <= '0;
        shreg   <= cmd.tx_data;
        r_stop  <= cmd.cmd_stop;
        r_read  <= cmd.cmd_read;
        r_nack  <= cmd.cmd_nack;
        busy_q  <= 1'b1;
      end else if (state != S_IDLE && !freeze) begin
        qcnt <= tick ? '0 : qcnt + 16'd1;
        if (tick) phase <= phase + 2'd1;
        // SDA is taken on the last clk of the SCL-high q2
        if (tick && phase == 2'd2 && in_bit)
          samp <= sda_in;
        if (qwrap && state == S_DATA) begin
          shreg   <= {shreg[6:0], samp};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (qwrap && ((state == S_ACK && !r_stop)
                      || state == S_STOP)) begin
          done_q <= 1'b1;
          if (r_read) rx_q  <= shreg;
          else        ack_q <= samp;
        end
        if (qwrap && state == S_STOP) busy_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte with a clock-sampled I2C slave model.
// The slave answers address 8'hA0/A1 and returns 8'h5A on reads.
module tb_i2c_master_byte;
  localparam int D = 4;
  localparam int M_ADDR = 0;
  localparam int M_WR   = 1;
  localparam int M_RD   = 2;
  localparam int M_IGN  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stretch = 1'b0;
  logic slv_low = 1'b0;
  logic scl_oen;
  logic sda_oen;
  wire  scl_w = scl_oen & ~stretch;
  wire  sda_w = sda_oen & ~slv_low;

  int npass = 0;
  int ntot  = 0;
  int probe_at = -1;
  logic probe_scl;
  logic probe_sda;

  i2c_master_byte_if cif ();

  i2c_master_byte #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl_w),
    .sda_in  (sda_w),
    .scl_oen (scl_oen),
    .sda_oen (sda_oen),
    .cmd     (cif)
  );

  always #5 clk = ~clk;

  // slave model
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic       active = 1'b0;
  logic [7:0] sh = 8'h00;
  logic [7:0] rd_byte = 8'h5A;
  int         cnt = 0;
  int         mode = M_ADDR;
  int         mnext = M_ADDR;
  int         stops = 0;

  always @(posedge clk) begin
    p_scl <= scl_w;
    p_sda <= sda_w;
    if (p_scl && scl_w && p_sda && !sda_w) begin
      cnt <= -1; active <= 1'b1; slv_low <= 1'b0;
      mode <= M_ADDR; mnext <= M_ADDR;
    end else if (p_scl && scl_w && !p_sda && sda_w) begin
      active <= 1'b0; slv_low <= 1'b0; stops <= stops + 1;
    end else if (active && !p_scl && scl_w) begin
      if (cnt < 8 && mode != M_RD) sh <= {sh[6:0], sda_w};
      if (cnt == 8 && mode == M_RD) mnext <= sda_w ? M_IGN : M_RD;
    end else if (active && p_scl && !scl_w) begin
      if (cnt == 7) begin
        cnt <= 8;
        if (mode == M_ADDR) begin
          if (sh[7:1] == 7'h50) begin
            slv_low <= 1'b1; mnext <= sh[0] ? M_RD : M_WR;
          end else begin
            slv_low <= 1'b0; mnext <= M_IGN;
          end
        end else begin
          slv_low <= (mode == M_WR);
        end
      end else if (cnt == 8) begin
        cnt <= 0; mode <= mnext;
        slv_low <= (mnext == M_RD) && !rd_byte[7];
      end else begin
        cnt <= cnt + 1;
        slv_low <= (mode == M_RD) && !rd_byte[6-cnt];
      end
    end
  end

  task automatic issue(input logic s, input logic st, input logic rd,
                       input logic nk, input logic [7:0] d);
    int w;
    cif.cmd_start = s; cif.cmd_stop = st; cif.cmd_read = rd;
    cif.cmd_nack = nk; cif.tx_data = d; cif.cmd_valid = 1'b1;
    w = 0;
    while (!cif.cmd_ready && w < 2000) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 2000) begin
      ntot++;
      $display("FAIL issue_ready got 0 want 1");
    end
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == probe_at) begin
        probe_scl = scl_oen; probe_sda = sda_oen;
      end
    end while (!cif.done && lat < 3000);
  endtask

  task automatic test_reset;
    cif.cmd_valid = 1'b0; cif.cmd_start = 1'b0; cif.cmd_stop = 1'b0;
    cif.cmd_read = 1'b0; cif.cmd_nack = 1'b0; cif.tx_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ntot++; if (scl_oen !== 1'b1) $display("FAIL rst_scl got %b want 1", scl_oen); else npass++;
    ntot++; if (sda_oen !== 1'b1) $display("FAIL rst_sda got %b want 1", sda_oen); else npass++;
    ntot++; if (cif.cmd_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", cif.cmd_ready); else npass++;
    ntot++; if (cif.rx_data !== 8'h00) $display("FAIL rst_rx got %h want 00", cif.rx_data); else npass++;
    ntot++; if (cif.ack_rx !== 1'b1) $display("FAIL rst_ack got %b want 1", cif.ack_rx); else npass++;
    ntot++; if (cif.done !== 1'b0) $display("FAIL rst_done got %b want 0", cif.done); else npass++;
    ntot++; if (cif.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", cif.busy); else npass++;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_write_ack;
    int lat;
    probe_at = 6 * D;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
    wait_done(lat);
    probe_at = -1;
    ntot++; if (lat < 40*D-1 || lat > 40*D+1) $display("FAIL wr_lat got %0d want %0d", lat, 40*D); else npass++;
    ntot++; if (cif.ack_rx !== 1'b0) $display("FAIL wr_ack got %b want 0", cif.ack_rx); else npass++;
    ntot++; if (cif.busy !== 1'b1) $display("FAIL wr_busy got %b want 1", cif.busy); else npass++;
    ntot++; if (probe_scl !== 1'b1) $display("FAIL wr_bit0_q2_scl got %b want 1", probe_scl); else npass++;
    @(posedge clk); #1;
    ntot++; if (scl_oen !== 1'b0) $display("FAIL wr_held_scl got %b want 0", scl_oen); else npass++;
  endtask

  task automatic test_nack_stop;
    int lat;
    int s0;
    s0 = stops;
    issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA2);
    wait_done(lat);
    ntot++; if (lat < 44*D-1 || lat > 44*D+1) $display("FAIL nk_lat got %0d want %0d", lat, 44*D); else npass++;
    ntot++; if (cif.ack_rx !== 1'b1) $display("FAIL nk_ack got %b want 1", cif.ack_rx); else npass++;
    ntot++; if (cif.busy !== 1'b0) $display("FAIL nk_busy got %b want 0", cif.busy); else npass++;
    ntot++; if ({scl_w, sda_w} !== 2'b11) $display("FAIL nk_bus got %b want 11", {scl_w, sda_w}); else npass++;
    ntot++; if (stops !== s0 + 1) $display("FAIL nk_stop got %0d want %0d", stops, s0 + 1); else npass++;
  endtask

  task automatic test_read;
    int lat;
    int s0;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'hA1);
    wait_done(lat);
    ntot++; if (cif.ack_rx !== 1'b0) $display("FAIL rd_addr_ack got %b want 0", cif.ack_rx); else npass++;
    s0 = stops;
    probe_at = 34 * D;
    issue(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    wait_done(lat);
    probe_at = -1;
    ntot++; if (lat < 40*D-1 || lat > 40*D+1) $display("FAIL rd_lat got %0d want %0d", lat, 40*D); else npass++;
    ntot++; if (cif.rx_data !== 8'h5A) $display("FAIL rd_data got %h want 5a", cif.rx_data); else npass++;
    ntot++; if (cif.ack_rx !== 1'b0) $display("FAIL rd_ack_hold got %b want 0", cif.ack_rx); else npass++;
    ntot++; if (probe_sda !== 1'b1) $display("FAIL rd_nack_slot got %b want 1", probe_sda); else npass++;
    ntot++; if (stops !== s0 + 1) $display("FAIL rd_stop got %0d want %0d", stops, s0 + 1); else npass++;
    ntot++; if (cif.busy !== 1'b0) $display("FAIL rd_busy got %b want 0", cif.busy); else npass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
    cif.cmd_start = 1'b0; cif.cmd_stop = 1'b1; cif.tx_data = 8'h33;
    cif.cmd_valid = 1'b1;
    wait_done(lat);
    ntot++; if (lat < 40*D-1 || lat > 40*D+1) $display("FAIL b2b_lat1 got %0d want %0d", lat, 40*D); else npass++;
    ntot++; if (cif.cmd_ready !== 1'b1) $display("FAIL b2b_ready_at_done got %b want 1", cif.cmd_ready); else npass++;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    ntot++; if (cif.cmd_ready !== 1'b0) $display("FAIL b2b_accepted got %b want 0", cif.cmd_ready); else npass++;
    wait_done(lat);
    ntot++; if (lat < 40*D-1 || lat > 40*D+1) $display("FAIL b2b_lat2 got %0d want %0d", lat, 40*D); else npass++;
    ntot++; if (cif.ack_rx !== 1'b0) $display("FAIL b2b_ack got %b want 0", cif.ack_rx); else npass++;
    ntot++; if (cif.busy !== 1'b0) $display("FAIL b2b_busy got %b want 0", cif.busy); else npass++;
  endtask

  task automatic test_reset_mid;
    int seen;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
    repeat (21 * D) @(posedge clk);
    #1;
    ntot++; if ({scl_oen, sda_oen} !== 2'b00) $display("FAIL mid_pre got %b want 00", {scl_oen, sda_oen}); else npass++;
    rst = 1'b1;
    @(posedge clk); #1;
    ntot++; if ({scl_oen, sda_oen} !== 2'b11) $display("FAIL mid_lines got %b want 11", {scl_oen, sda_oen}); else npass++;
    ntot++; if (cif.cmd_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", cif.cmd_ready); else npass++;
    ntot++; if (cif.busy !== 1'b0) $display("FAIL mid_busy got %b want 0", cif.busy); else npass++;
    rst = 1'b0;
    seen = 0;
    repeat (60 * D) begin
      @(posedge clk); #1;
      if (cif.done) seen++;
    end
    ntot++; if (seen !== 0) $display("FAIL mid_done got %0d pulses want 0", seen); else npass++;
  endtask

  task automatic test_stretch;
    int lat;
    int want;
`ifdef I2C_CLK_STRETCH_EN
    want = 44 * D + 100;
`else
    want = 44 * D;
`endif
    issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA2);
    fork
      wait_done(lat);
      begin
        int k;
        int r;
        logic prev;
        k = 0; r = 0; prev = scl_oen;
        while (r < 3 && k < 2000) begin
          @(negedge clk); k++;
          if (scl_oen && !prev) r++;
          prev = scl_oen;
        end
        stretch = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        stretch = 1'b0;
      end
    join
    ntot++; if (lat < want-1 || lat > want+1) $display("FAIL str_lat got %0d want %0d", lat, want); else npass++;
  endtask

  initial begin
    test_reset;
    test_write_ack;
    test_nack_stop;
    test_read;
    test_back_to_back;
    test_reset_mid;
    test_stretch;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
